hazard_controller: RTL and testbench

Pipeline hazard controller that sequences stalls and flushes around the operand forwarding network. It detects load-use hazards that forwarding cannot cover (load data is forwarded only from WB, never from MEM), holds the front of the pipeline while a multi-cycle EX unit (divider/FP divider) runs, and flushes wrong-path instructions on a taken branch. It sits beside the ID/EX pipeline registers and drives their enable/flush controls.

---
 rtl/hazard_controller.sv | 189 ++++++++++++++++++
 tb/tb_hazard_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller
//
// Sequences pipeline stalls and flushes around the operand forwarding network.
// Three situations are handled:
//   - Load-use hazards that forwarding cannot cover. Load data is forwarded
//     only from WB, so the consumer is held for two cycles.
//   - Multi-cycle EX operations (divider / FP divider). The front of the
//     pipeline is held until the result arrives or the watchdog expires.
//   - Taken branches. The wrong-path instructions in IF-ID and ID-EX are
//     flushed.
//
// The stall and flush controls are combinational (Mealy) outputs of the state
// and the current inputs. They are forced low while rst is asserted.
//
// Ports
//   clk, rst                    pipeline clock, async active-high reset
//   id_rs_1, id_rs_2            source register ids of the ID instruction
//   id_uses_rs_1/2              ID instruction actually reads that source
//   id_read_float               ID sources are float registers
//   ex_write_back_id            destination id of the EX instruction
//   ex_mem_read                 EX instruction is a load
//   ex_reg_write(_float)        EX writes the integer / float register file
//   ex_multi_start              EX starts a multi-cycle op this cycle
//   multi_done                  multi-cycle result valid (1-cycle pulse)
//   branch_taken                EX resolved a taken branch/jump
//   stall_if, stall_id          hold PC / IF-ID register
//   stall_ex                    hold ID-EX register
//   flush_id, flush_ex,
//   flush_mem                   bubble into IF-ID / ID-EX / EX-MEM
//   multi_timeout               sticky watchdog-expired flag
//   stall_cycles                saturating count of cycles with stall_if high
module hazard_controller #(
    parameter int MULTI_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_1,
    input  logic [4:0]  id_rs_2,
    input  logic        id_uses_rs_1,
    input  logic        id_uses_rs_2,
    input  logic        id_read_float,
    input  logic [4:0]  ex_write_back_id,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic        ex_reg_write_float,
    input  logic        ex_multi_start,
    input  logic        multi_done,
    input  logic        branch_taken,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic        multi_timeout,
    output logic [31:0] stall_cycles
);

    localparam int CNT_W = (MULTI_TIMEOUT > 2) ? $clog2(MULTI_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_WAIT  = 2'd1,
        ST_MULTI_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic             reg_match;
    logic             dest_qualifies;
    logic             load_use;

    logic             stall_if_c, stall_id_c, stall_ex_c;
    logic             flush_id_c, flush_ex_c, flush_mem_c;

    // Integer x0 never creates a hazard. Float f0 is a real register.
    always_comb begin
        reg_match = (id_uses_rs_1 && (ex_write_back_id == id_rs_1)) ||
                    (id_uses_rs_2 && (ex_write_back_id == id_rs_2));
        dest_qualifies = (ex_reg_write && !id_read_float && (ex_write_back_id != 5'd0)) ||
                         (ex_reg_write_float && id_read_float);
        load_use = ex_mem_read && reg_match && dest_qualifies;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        flush_id_c  = 1'b0;
        flush_ex_c  = 1'b0;
        flush_mem_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    flush_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                end else if (ex_multi_start) begin
                    // A result that is already valid needs no wait at all.
                    if (!multi_done) begin
                        stall_if_c  = 1'b1;
                        stall_id_c  = 1'b1;
                        stall_ex_c  = 1'b1;
                        flush_mem_c = 1'b1;
                        cnt_d       = CNT_LOAD;
                        state_d     = ST_MULTI_WAIT;
                    end
                end else if (load_use) begin
                    stall_if_c = 1'b1;
                    stall_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                    state_d    = ST_LOAD_WAIT;
                end
            end

            ST_LOAD_WAIT: begin
                // The load is in MEM now. Its data is not forwardable yet,
                // and EX holds a bubble, so branch_taken is meaningless here.
                stall_if_c = 1'b1;
                stall_id_c = 1'b1;
                flush_ex_c = 1'b1;
                state_d    = ST_RUN;
            end

            ST_MULTI_WAIT: begin
                if (multi_done) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_ONE) begin
                    // The op is abandoned in the cycle its count would reach
                    // zero. That gives MULTI_TIMEOUT-1 stall cycles counted
                    // from the start cycle.
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    stall_if_c  = 1'b1;
                    stall_id_c  = 1'b1;
                    stall_ex_c  = 1'b1;
                    flush_mem_c = 1'b1;
                    cnt_d       = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_if_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Controls drop within the reset cycle, whatever the inputs show.
    assign stall_if      = stall_if_c  & ~rst;
    assign stall_id      = stall_id_c  & ~rst;
    assign stall_ex      = stall_ex_c  & ~rst;
    assign flush_id      = flush_id_c  & ~rst;
    assign flush_ex      = flush_ex_c  & ~rst;
    assign flush_mem     = flush_mem_c & ~rst;
    assign multi_timeout = timeout_q;
    assign stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs_1, id_rs_2, ex_write_back_id;
    logic        id_uses_rs_1, id_uses_rs_2, id_read_float;
    logic        ex_mem_read, ex_reg_write, ex_reg_write_float;
    logic        ex_multi_start, multi_done, branch_taken;
    logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem;
    logic        multi_timeout;
    logic [31:0] stall_cycles;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: remaining load stall cycles, and the age of an
    // outstanding multi-cycle op in cycles since it started.
    int          load_left;
    bit          multi_act;
    int          multi_age;
    bit          to_m;
    logic [31:0] cnt_m;

    hazard_controller #(.MULTI_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs_1(id_rs_1), .id_rs_2(id_rs_2),
        .id_uses_rs_1(id_uses_rs_1), .id_uses_rs_2(id_uses_rs_2),
        .id_read_float(id_read_float),
        .ex_write_back_id(ex_write_back_id),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_reg_write_float(ex_reg_write_float),
        .ex_multi_start(ex_multi_start), .multi_done(multi_done),
        .branch_taken(branch_taken),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .multi_timeout(multi_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic rf,
                          input logic [4:0] wb, input logic mr, input logic rw,
                          input logic rwf, input logic ms, input logic md,
                          input logic bt);
        id_rs_1 = rs1; id_rs_2 = rs2;
        id_uses_rs_1 = u1; id_uses_rs_2 = u2; id_read_float = rf;
        ex_write_back_id = wb; ex_mem_read = mr;
        ex_reg_write = rw; ex_reg_write_float = rwf;
        ex_multi_start = ms; multi_done = md; branch_taken = bt;
    endtask

    function automatic bit model_load_use();
        bit hit1, hit2, ok;
        hit1 = id_uses_rs_1 && (ex_write_back_id == id_rs_1);
        hit2 = id_uses_rs_2 && (ex_write_back_id == id_rs_2);
        if (id_read_float) ok = ex_reg_write_float;
        else               ok = ex_reg_write && (ex_write_back_id != 5'd0);
        return ex_mem_read && (hit1 || hit2) && ok;
    endfunction

    function automatic logic [31:0] got_ctrl();
        return {26'd0, stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem};
    endfunction

    task automatic model_reset();
        load_left = 0; multi_act = 0; multi_age = 0; to_m = 0; cnt_m = 0;
    endtask

    // One pipeline cycle. Inputs are already driven. The bench checks on the
    // falling edge, then advances the model and moves past the next rising edge.
    task automatic step();
        logic [5:0] e;
        bit to_set;
        to_set = 0;
        @(negedge clk);
        e = 6'b000000;
        if (load_left > 0) begin
            e = 6'b110010;
            load_left = 0;
        end else if (multi_act) begin
            if (multi_done) begin
                multi_act = 0;
            end else if (multi_age == TO - 1) begin
                multi_act = 0;
                to_set = 1;
            end else begin
                e = 6'b111001;
                multi_age++;
            end
        end else if (branch_taken) begin
            e = 6'b000110;
        end else if (ex_multi_start) begin
            if (!multi_done) begin
                e = 6'b111001;
                multi_act = 1;
                multi_age = 1;
            end
        end else if (model_load_use()) begin
            e = 6'b110010;
            load_left = 1;
        end
        check_val("ctrl", got_ctrl(), {26'd0, e});
        check_val("stall_cycles", stall_cycles, cnt_m);
        check_val("multi_timeout", {31'd0, multi_timeout}, {31'd0, to_m});
        if (e[5] && cnt_m != 32'hFFFF_FFFF) cnt_m++;
        if (to_set) to_m = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(5, 5, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0);
        model_reset();
        #1;
        check_val("rst_ctrl", got_ctrl(), 32'd0);
        check_val("rst_cnt", stall_cycles, 32'd0);
        check_val("rst_to", {31'd0, multi_timeout}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Load x5 in EX, ID reads rs_1=5: two stall cycles.
        set_in(5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0); step();
        set_in(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check_val("ld_cnt", stall_cycles, 32'd2);
        idle(); step();

        // Load writes x0, ID reads x0: no stall.
        set_in(0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0); step();
        // Float load f0 and float read of f0: stall.
        set_in(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0); step();
        idle(); step();
        // Float load and integer read of id 3: no stall.
        set_in(3, 0, 1, 0, 0, 3, 1, 0, 1, 0, 0, 0); step();
        check_val("ld_cnt2", stall_cycles, 32'd4);

        // Multi-cycle op finishing 5 cycles later.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        idle();
        repeat (4) step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        idle(); step();
        check_val("mc_cnt", stall_cycles, 32'd9);

        // A branch outranks a multi start and a load-use.
        set_in(5, 0, 1, 0, 0, 5, 1, 1, 0, 1, 0, 1); step();
        idle(); step();

        // Watchdog expiry: multi_timeout becomes sticky.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        idle();
        repeat (9) step();
        check_val("to_sticky", {31'd0, multi_timeout}, 32'd1);
        check_val("to_cnt", stall_cycles, 32'd16);

        // Reset during MULTI_WAIT, with hazards still presented on the inputs.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        idle(); step(); step();
        set_in(5, 5, 1, 1, 0, 5, 1, 1, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        check_val("mid_rst_ctrl", got_ctrl(), 32'd0);
        check_val("mid_rst_cnt", stall_cycles, 32'd0);
        check_val("mid_rst_to", {31'd0, multi_timeout}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        set_in(7, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0); step();
        set_in(7, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        idle(); step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0),
                   5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0),
                   multi_act ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 7) == 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
